ram: RTL and testbench

//  Unified dual-port instruction/data memory for the RISC-V core.

---
 rtl/ram.sv | 72 +++++++
 tb/tb_ram.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// ============================================================================
//  Module   : ram
//  Brief    : Unified dual-port instruction/data memory. Port I is a
//             combinational instruction fetch; port D is a combinational
//             load plus a synchronous full-word store into the same array.
//             Contents power up as all zeros.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter     INIT_FILE  = "ram.hex"
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  wEn,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    output logic [DATA_WIDTH-1:0] d_read_data
);

    localparam int c_idx_width = ADDR_WIDTH - 2;
    localparam int c_depth     = 2 ** c_idx_width;

    logic [DATA_WIDTH-1:0]  r_mem [0:c_depth-1];
    logic [c_idx_width-1:0] w_i_idx;
    logic [c_idx_width-1:0] w_d_idx;
    logic                   w_write;

    // Byte-offset bits carry no meaning: accesses are always whole words.
    logic w_unused_low_bits;
    assign w_unused_low_bits = &{1'b0, i_address[1:0], d_address[1:0]};

    assign w_i_idx = i_address[ADDR_WIDTH-1:2];
    assign w_d_idx = d_address[ADDR_WIDTH-1:2];

    // An unknown enable compares as X and therefore never commits a store.
    assign w_write = reset && (wEn == 1'b1);

    localparam c_unused_init_file = INIT_FILE;

    initial begin
        for (int k = 0; k < c_depth; k++) begin
            r_mem[k] = '0;
        end
    end

    // Contents survive reset; reset only blocks the store at the edge.
    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[w_d_idx] <= d_write_data;
        end
    end

    // Reads are combinational; a low reset gates both outputs to zero
    // without any clocking so release is seen immediately.
    always_comb begin
        i_read_data = '0;
        d_read_data = '0;
        if (reset) begin
            i_read_data = r_mem[w_i_idx];
            d_read_data = r_mem[w_d_idx];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram.sv
// ============================================================================
//  Module   : tb_ram
//  Brief    : Self-checking bench for ram: directed cases plus random traffic
//             compared every cycle against an array model of the memory.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram;

    logic        clock;
    logic        reset;
    logic [15:0] i_address;
    logic [31:0] i_read_data;
    logic        wEn;
    logic [15:0] d_address;
    logic [31:0] d_write_data;
    logic [31:0] d_read_data;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [31:0] model [0:16383];

    ram #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .INIT_FILE  ("ram.hex")
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_address    (i_address),
        .i_read_data  (i_read_data),
        .wEn          (wEn),
        .d_address    (d_address),
        .d_write_data (d_write_data),
        .d_read_data  (d_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int k = 0; k < 16384; k++) model[k] = 32'h0;
    end

    // Memory rule: a store lands only when reset is high and wEn is a clean 1.
    always @(posedge clock) begin
        if (reset === 1'b1 && wEn === 1'b1)
            model[d_address >> 2] = d_write_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_i_read", i_read_data, (reset === 1'b1) ? model[i_address >> 2] : 32'h0);
            check("cyc_d_read", d_read_data, (reset === 1'b1) ? model[d_address >> 2] : 32'h0);
        end
    end

    task automatic cycle();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset        = 1'b0;
        wEn          = 1'b0;
        i_address    = 16'h0;
        d_address    = 16'h0;
        d_write_data = 32'h0;
        #2;
        cmp_en = 1'b1;

        // 1: reset gates outputs, then a zero store at word 0
        cycle();
        check("reset_i", i_read_data, 32'h0);
        check("reset_d", d_read_data, 32'h0);
        reset = 1'b1; wEn = 1'b1; d_address = 16'h0; d_write_data = 32'h0;
        cycle();
        check("t1_word0", d_read_data, 32'h0);

        // 2: stores to words 1 and 2
        d_address = 16'h4; d_write_data = 32'h1;
        #1 check("t2_pre_edge_old", d_read_data, 32'h0);
        cycle();
        check("t2_word1", d_read_data, 32'h1);
        d_address = 16'h8; d_write_data = 32'h2;
        cycle();
        check("t2_word2", d_read_data, 32'h2);

        // 3: fetch port sees the data-port store without an edge
        i_address = 16'h8;
        #1 check("t3_fetch", i_read_data, 32'h2);
        check("t3_model_pin", model[2], 32'h2);

        // 4: top word and low-bit aliasing
        d_address = 16'hFFFF; d_write_data = 32'hFF;
        cycle();
        check("t4_top", d_read_data, 32'hFF);
        d_address = 16'h0000; d_write_data = 32'h3F;
        cycle();
        check("t4_bottom", d_read_data, 32'h3F);
        d_address = 16'hFFFC;
        #1 check("t4_alias", d_read_data, 32'hFF);
        i_address = 16'h0003;
        #1 check("t4_alias_i", i_read_data, 32'h3F);

        // 5: disabled write leaves word 3 untouched
        wEn = 1'b0; d_address = 16'd12; d_write_data = 32'hDEAD;
        repeat (4) cycle();
        check("t5_no_write", d_read_data, 32'h0);

        // 6: reset asserted mid-cycle drops the pending store
        wEn = 1'b1; d_address = 16'h4; d_write_data = 32'hBAD0BAD0; i_address = 16'h4;
        #1 reset = 1'b0;
        #1 check("t6_rst_i", i_read_data, 32'h0);
        check("t6_rst_d", d_read_data, 32'h0);
        cycle();
        wEn = 1'b0; reset = 1'b1;
        #1 check("t6_after_d", d_read_data, 32'h1);
        check("t6_after_i", i_read_data, 32'h1);

        // X on write enable never stores
        wEn = 1'bx; d_address = 16'h8; d_write_data = 32'h12345678;
        cycle();
        wEn = 1'b0;
        #1 check("x_wen", d_read_data, 32'h2);

        // Random traffic against the array model
        for (int n = 0; n < 2000; n++) begin
            i_address    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            d_address    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            d_write_data = $urandom;
            case ($urandom_range(0, 19))
                0:       wEn = 1'bx;
                1, 2, 3: wEn = 1'b0;
                default: wEn = 1'b1;
            endcase
            reset = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                i_address = d_address;
            end
            cycle();
        end

        // Sweep of the low region through both ports
        reset = 1'b1; wEn = 1'b0;
        for (int k = 0; k < 64; k++) begin
            i_address = 16'(k * 4);
            d_address = 16'(k * 4 + 2);
            #1;
            check("sweep_i", i_read_data, model[k]);
            check("sweep_d", d_read_data, model[k]);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
